mult_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational doubling multiplier (`data_out = data_in * 2`, 32-bit, truncating) among `N_REQ` valid/ready requesters. Each requester's operand is captured into a register and driven onto the multiplier input. The multiplier result is registered and returned on a single response stream, tagged with the requester index and an overflow flag. The block sits between the PL-side producers and the shared multiplier instance.

---
 rtl/mult_share_if.sv | 26 ++
 rtl/mult_share_arbiter.sv | 108 ++++++++++
 tb/tb_mult_share_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_if.sv
// Request/response bundle between the requesters, the arbiter and the downstream consumer.
// The arbiter takes the slave side; producers and the consumer sit on the master side.
interface mult_share_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_W-1:0]       rsp_data;
  logic [ID_W-1:0]         rsp_id;
  logic                    rsp_ovf;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one external combinational doubling multiplier among
// N_REQ valid/ready requesters; results return on one tagged response stream.
module mult_share_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  mult_share_if.slave       bus,
  output logic [DATA_W-1:0] mult_in,
  input  logic [DATA_W-1:0] mult_out,
  output logic              busy,
  output logic [15:0]       done_cnt
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t            state_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   id_reg;
  logic [DATA_W-1:0] op_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic              rsp_ovf_reg;
  logic [15:0]       done_cnt_reg;

  logic [ID_W-1:0]   cand_idx [N_REQ];
  logic [DATA_W-1:0] op_arr   [N_REQ];
  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  logic              accept;

  // cand_idx[k] is the k-th requester to look at, starting from rr_ptr
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign cand_idx[gi] = ID_W'((32'(rr_ptr_reg) + 32'(gi)) % 32'(N_REQ));
      assign op_arr[gi]   = bus.req_data[gi*DATA_W +: DATA_W];
      assign bus.req_ready[gi] = accept && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // Scan from the far end so the closest valid requester to rr_ptr wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[cand_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  assign accept = (state_reg == IDLE) && grant_found && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      id_reg        <= '0;
      op_reg        <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
      rsp_ovf_reg   <= 1'b0;
      done_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg     <= op_arr[grant_idx];
            id_reg     <= grant_idx;
            rr_ptr_reg <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            state_reg  <= CALC;
          end
        end
        CALC: begin
          rsp_data_reg  <= mult_out;
          rsp_id_reg    <= id_reg;
          rsp_ovf_reg   <= op_reg[DATA_W-1];
          rsp_valid_reg <= 1'b1;
          state_reg     <= HOLD;
        end
        HOLD: begin
          // Only sampled here, so ready on the rising edge of rsp_valid never counts
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            done_cnt_reg  <= done_cnt_reg + 16'd1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mult_in       = op_reg;
  assign busy          = (state_reg != IDLE);
  assign done_cnt      = done_cnt_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_ovf   = rsp_ovf_reg;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: stimulus pushes expected responses into a
// queue, a negedge monitor pops and compares on every response handshake.
module tb_mult_share_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] mult_in;
  logic [DW-1:0] mult_out;
  logic          busy;
  logic [15:0]   done_cnt;

  mult_share_if #(.N_REQ(N), .DATA_W(DW), .ID_W(IW)) bus ();

  mult_share_arbiter #(.N_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mult_in  (mult_in),
    .mult_out (mult_out),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  // The shared doubling multiplier
  assign mult_out = mult_in << 1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          ovf;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks   = 0;
  int failures = 0;

  int          b_id [4];
  logic [31:0] b_op [4];
  logic [31:0] b_ed [4];
  logic        b_eo [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: valid & ready at negedge means a handshake on the next edge
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stray_rsp actual id=%0d data=0x%08h required=no response", bus.rsp_id, bus.rsp_data);
      end else begin
        e = q.pop_front();
        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        chk("rsp_data", bus.rsp_data, e.data);
        chk("rsp_ovf", 32'(bus.rsp_ovf), 32'(e.ovf));
        $display("rsp id=%0d data=0x%08h ovf=%0d done_cnt=%0d", bus.rsp_id, bus.rsp_data, bus.rsp_ovf, done_cnt);
      end
    end
  end

  // Present one operand, wait for its grant, accept it; returns 1ns after the accept edge
  task automatic issue(input int id, input logic [31:0] op, input logic [31:0] ed,
                       input logic eo, input bit push);
    int n = 0;
    bus.req_data[id*DW +: DW] = op;
    bus.req_valid[id] = 1'b1;
    #1;
    while (!bus.req_ready[id] && n < 40) begin
      tick();
      n++;
    end
    chk("grant_wait", 32'(bus.req_ready[id]), 32'd1);
    if (!bus.req_ready[id]) begin
      bus.req_valid[id] = 1'b0;
      return;
    end
    if (push) q.push_back('{IW'(id), ed, eo});
    $display("req id=%0d op=0x%08h accepted", id, op);
    tick();
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask

  // All listed requesters valid at once; grants must follow b_id order, 3 cycles apart
  task automatic batch(input int cnt);
    int last = 0;
    for (int i = 0; i < cnt; i++) begin
      bus.req_data[b_id[i]*DW +: DW] = b_op[i];
      bus.req_valid[b_id[i]] = 1'b1;
    end
    #1;
    for (int k = 0; k < cnt; k++) begin
      int n = 0;
      while (bus.req_ready == '0 && n < 40) begin
        tick();
        n++;
      end
      chk("grant_order", 32'(bus.req_ready), 32'(1 << b_id[k]));
      if (k > 0) chk("grant_gap", 32'(cyc - last), 32'd3);
      last = cyc;
      q.push_back('{IW'(b_id[k]), b_ed[k], b_eo[k]});
      $display("req id=%0d op=0x%08h accepted", b_id[k], b_op[k]);
      tick();
      bus.req_valid[b_id[k]] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;

    // Reset state, with every requester asking so req_ready forcing is visible
    rst = 1'b1;
    tick();
    bus.req_valid = '1;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk("rst_mult_in", mult_in, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_ovf", 32'(bus.rsp_ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    tick();

    // Single request and its latency
    bus.rsp_ready = 1'b1;
    issue(1, 32'h0000_0015, 32'h0000_002A, 1'b0, 1'b1);
    chk("single_rsp_valid_early", 32'(bus.rsp_valid), 32'd0);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_mult_in", mult_in, 32'h0000_0015);
    tick();
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_rsp_data", bus.rsp_data, 32'h0000_002A);
    tick();
    chk("single_rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
    chk("single_busy_after", 32'(busy), 32'd0);
    chk("single_done_cnt", 32'(done_cnt), 32'd1);

    // Contention straight out of reset
    rst = 1'b1;
    b_id = '{0, 1, 2, 3};
    b_op = '{32'd1, 32'd2, 32'd3, 32'd4};
    b_ed = '{32'd2, 32'd4, 32'd6, 32'd8};
    b_eo = '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bus.req_data[i*DW +: DW] = b_op[i];
      bus.req_valid[i] = 1'b1;
    end
    tick();
    rst = 1'b0;
    batch(4);
    drain();
    chk("contention_done_cnt", 32'(done_cnt), 32'd4);

    // Fairness: after requester 2, requester 3 beats 0
    issue(2, 32'h0000_0040, 32'h0000_0080, 1'b0, 1'b1);
    drain();
    b_id = '{3, 0, 0, 0};
    b_op = '{32'h0000_0100, 32'h0000_0007, 32'd0, 32'd0};
    b_ed = '{32'h0000_0200, 32'h0000_000E, 32'd0, 32'd0};
    b_eo = '{1'b0, 1'b0, 1'b0, 1'b0};
    batch(2);
    drain();
    chk("fair_done_cnt", 32'(done_cnt), 32'd7);

    // Backpressure: 10 cycles held in HOLD while requester 1 waits
    bus.rsp_ready = 1'b0;
    issue(0, 32'h1234_5678, 32'h2468_ACF0, 1'b0, 1'b1);
    tick();
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    bus.req_data[1*DW +: DW] = 32'h0000_0005;
    bus.req_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_rsp_data", bus.rsp_data, 32'h2468_ACF0);
      chk("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("bp_done_cnt_held", 32'(done_cnt), 32'd7);
    bus.rsp_ready = 1'b1;
    issue(1, 32'h0000_0005, 32'h0000_000A, 1'b0, 1'b1);
    drain();
    chk("bp_done_cnt", 32'(done_cnt), 32'd9);

    // Overflow flag
    issue(0, 32'h8000_0001, 32'h0000_0002, 1'b1, 1'b1);
    drain();
    issue(1, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1);
    drain();
    chk("ovf_done_cnt", 32'(done_cnt), 32'd11);

    // Reset while in CALC: no response, rr_ptr back to 0 (would otherwise grant 3)
    issue(2, 32'h0000_0010, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rcalc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rcalc_busy", 32'(busy), 32'd0);
    chk("rcalc_done_cnt", 32'(done_cnt), 32'd0);
    chk("rcalc_mult_in", mult_in, 32'd0);
    bus.req_valid[0] = 1'b1;
    bus.req_valid[3] = 1'b1;
    #1;
    chk("rcalc_rr_ptr", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rcalc_quiet", 32'(bus.rsp_valid), 32'd0);
    end

    // Reset while in HOLD (rr_ptr would be 2, granting 3 over 0)
    bus.rsp_ready = 1'b0;
    issue(1, 32'h0000_0020, 32'd0, 1'b0, 1'b0);
    tick();
    chk("rhold_rsp_valid_pre", 32'(bus.rsp_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    chk("rhold_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rhold_busy", 32'(busy), 32'd0);
    chk("rhold_done_cnt", 32'(done_cnt), 32'd0);
    bus.req_valid[0] = 1'b1;
    bus.req_valid[3] = 1'b1;
    #1;
    chk("rhold_rr_ptr", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rhold_quiet", 32'(bus.rsp_valid), 32'd0);
    end

    // done_cnt wrap from a preloaded 0xFFFF
    force dut.done_cnt_reg = 16'hFFFF;
    #1;
    release dut.done_cnt_reg;
    tick();
    issue(3, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);
    drain();
    chk("wrap_done_cnt", 32'(done_cnt), 32'd0);

    tick();
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
